// File: rtl/gradient_pipe.sv
// Two-stage 3x3 Sobel/Prewitt gradient engine over a WIN x WIN window, valid/ready handshake.
// Optional macro GRADIENT_MAG_EN adds the Gmag = |Gx| + |Gy| output.
module gradient_pipe #(
  parameter int PIX_W = 8,
  parameter int WIN   = 6,
  parameter int OUT_W = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 win_valid,
  output logic                                 win_ready,
  input  logic [PIX_W*WIN*WIN-1:0]             window,
  input  logic                                 kernel_sel,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUT_W*(WIN-2)*(WIN-2)-1:0]     Gx,
  output logic [OUT_W*(WIN-2)*(WIN-2)-1:0]     Gy
`ifdef GRADIENT_MAG_EN
  ,
  output logic [OUT_W*(WIN-2)*(WIN-2)-1:0]     Gmag
`endif
);

  localparam int OUT_N = WIN - 2;
  localparam int NPOS  = OUT_N * OUT_N;
  localparam int DW    = PIX_W + 1;
  localparam int GW    = PIX_W + 3;

  if (WIN < 3) begin : g_bad_win
    $fatal(1, "gradient_pipe: WIN must be >= 3");
  end
  if (OUT_W < PIX_W + 3) begin : g_bad_out_w
    $fatal(1, "gradient_pipe: OUT_W must be >= PIX_W+3");
  end

  logic signed [DW-1:0] w_pix [WIN][WIN];
  logic signed [DW-1:0] w_dh  [WIN][OUT_N];
  logic signed [DW-1:0] w_dv  [OUT_N][WIN];
  logic signed [DW-1:0] r_dh  [WIN][OUT_N];
  logic signed [DW-1:0] r_dv  [OUT_N][WIN];
  logic signed [GW-1:0] w_gx  [NPOS];
  logic signed [GW-1:0] w_gy  [NPOS];
  logic signed [OUT_W-1:0] r_gx [NPOS];
  logic signed [OUT_W-1:0] r_gy [NPOS];
  logic r_ksel;
  logic r_s1_valid;
  logic r_out_valid;
  logic w_en;

  assign w_en      = !r_out_valid || out_ready;
  assign win_ready = w_en;
  assign out_valid = r_out_valid;

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_pix_r
      for (gj = 0; gj < WIN; gj++) begin : g_pix_c
        assign w_pix[gi][gj] = {1'b0, window[(gi*WIN+gj)*PIX_W +: PIX_W]};
      end
    end

    // Stage 1 differences: horizontal across each row, vertical down each column.
    for (gi = 0; gi < WIN; gi++) begin : g_d_a
      for (gj = 0; gj < OUT_N; gj++) begin : g_d_b
        assign w_dh[gi][gj] = w_pix[gi][gj] - w_pix[gi][gj+2];
        assign w_dv[gj][gi] = w_pix[gj][gi] - w_pix[gj+2][gi];
      end
    end

    for (gi = 0; gi < OUT_N; gi++) begin : g_s2_r
      for (gj = 0; gj < OUT_N; gj++) begin : g_s2_c
        logic signed [GW-1:0] w_x0, w_x1, w_x2, w_y0, w_y1, w_y2;
        assign w_x0 = GW'(r_dh[gi][gj]);
        assign w_x1 = r_ksel ? GW'(r_dh[gi+1][gj]) : (GW'(r_dh[gi+1][gj]) <<< 1);
        assign w_x2 = GW'(r_dh[gi+2][gj]);
        assign w_y0 = GW'(r_dv[gi][gj]);
        assign w_y1 = r_ksel ? GW'(r_dv[gi][gj+1]) : (GW'(r_dv[gi][gj+1]) <<< 1);
        assign w_y2 = GW'(r_dv[gi][gj+2]);
        assign w_gx[gi*OUT_N+gj] = w_x0 + w_x1 + w_x2;
        assign w_gy[gi*OUT_N+gj] = w_y0 + w_y1 + w_y2;
      end
    end

    for (gi = 0; gi < NPOS; gi++) begin : g_out
      assign Gx[gi*OUT_W +: OUT_W] = r_gx[gi];
      assign Gy[gi*OUT_W +: OUT_W] = r_gy[gi];
    end
  endgenerate

`ifdef GRADIENT_MAG_EN
  logic [OUT_W-1:0] w_mag [NPOS];
  logic [OUT_W-1:0] r_mag [NPOS];
  generate
    for (gi = 0; gi < NPOS; gi++) begin : g_mag
      logic signed [GW-1:0] w_ax, w_ay;
      assign w_ax = (w_gx[gi] < 0) ? -w_gx[gi] : w_gx[gi];
      assign w_ay = (w_gy[gi] < 0) ? -w_gy[gi] : w_gy[gi];
      assign w_mag[gi] = OUT_W'($unsigned(w_ax)) + OUT_W'($unsigned(w_ay));
      assign Gmag[gi*OUT_W +: OUT_W] = r_mag[gi];
    end
  endgenerate
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_ksel      <= 1'b0;
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < OUT_N; c++) begin
          r_dh[r][c] <= '0;
          r_dv[c][r] <= '0;
        end
      end
      for (int n = 0; n < NPOS; n++) begin
        r_gx[n] <= '0;
        r_gy[n] <= '0;
`ifdef GRADIENT_MAG_EN
        r_mag[n] <= '0;
`endif
      end
    end else if (w_en) begin
      r_s1_valid  <= win_valid;
      r_out_valid <= r_s1_valid;
      // Data stages only capture real transfers so idle bubbles never disturb held data.
      if (win_valid) begin
        r_ksel <= kernel_sel;
        for (int r = 0; r < WIN; r++) begin
          for (int c = 0; c < OUT_N; c++) begin
            r_dh[r][c] <= w_dh[r][c];
            r_dv[c][r] <= w_dv[c][r];
          end
        end
      end
      if (r_s1_valid) begin
        for (int n = 0; n < NPOS; n++) begin
          r_gx[n] <= OUT_W'(w_gx[n]);
          r_gy[n] <= OUT_W'(w_gy[n]);
`ifdef GRADIENT_MAG_EN
          r_mag[n] <= w_mag[n];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_gradient_pipe.sv
// Directed bench for gradient_pipe: default 6x6 instance plus a 3x3 PIX_W=10 instance.
module tb_gradient_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic          win_valid, win_ready, kernel_sel, out_valid, out_ready;
  logic [287:0]  window;
  logic [255:0]  Gx, Gy;
`ifdef GRADIENT_MAG_EN
  logic [255:0]  Gmag;
`endif

  logic          win_valid3, win_ready3, kernel_sel3, out_valid3, out_ready3;
  logic [89:0]   window3;
  logic [12:0]   Gx3, Gy3;
`ifdef GRADIENT_MAG_EN
  logic [12:0]   Gmag3;
`endif

  gradient_pipe u_dut (
    .clk(clk), .reset(reset), .win_valid(win_valid), .win_ready(win_ready),
    .window(window), .kernel_sel(kernel_sel), .out_valid(out_valid),
    .out_ready(out_ready), .Gx(Gx), .Gy(Gy)
`ifdef GRADIENT_MAG_EN
    , .Gmag(Gmag)
`endif
  );

  gradient_pipe #(.PIX_W(10), .WIN(3), .OUT_W(13)) u_dut3 (
    .clk(clk), .reset(reset), .win_valid(win_valid3), .win_ready(win_ready3),
    .window(window3), .kernel_sel(kernel_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3), .Gx(Gx3), .Gy(Gy3)
`ifdef GRADIENT_MAG_EN
    , .Gmag(Gmag3)
`endif
  );

  function automatic logic signed [15:0] gx_at(int n);
    return Gx[n*16 +: 16];
  endfunction
  function automatic logic signed [15:0] gy_at(int n);
    return Gy[n*16 +: 16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // w[r][c] = m*c
  task automatic set_ramp(int m);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        window[(r*6+c)*8 +: 8] = 8'(m*c);
  endtask

  task automatic test_reset();
    reset = 1'b1; win_valid = 1'b0; kernel_sel = 1'b0; out_ready = 1'b1; window = '1;
    win_valid3 = 1'b0; kernel_sel3 = 1'b0; out_ready3 = 1'b1; window3 = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (win_ready !== 1'b1) begin errors++; $display("FAIL reset_win_ready got=%b exp=1", win_ready); end
    checks++; if (Gx !== '0) begin errors++; $display("FAIL reset_gx got=%h exp=0", Gx); end
    checks++; if (Gy !== '0) begin errors++; $display("FAIL reset_gy got=%h exp=0", Gy); end
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid3 got=%b exp=0", out_valid3); end
    reset = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_ramp(input logic ksel, input int exp_gx);
    set_ramp(10); kernel_sel = ksel; win_valid = 1'b1; out_ready = 1'b1;
    step();
    // Flip the kernel select while the window is in flight; result must not change.
    win_valid = 1'b0; kernel_sel = ~ksel; window = '1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_latency got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid got=%b exp=1", out_valid); end
    for (int n = 0; n < 16; n++) begin
      checks++; if (gx_at(n) !== 16'(exp_gx)) begin errors++; $display("FAIL ramp_gx[%0d] got=%0d exp=%0d", n, gx_at(n), exp_gx); end
      checks++; if (gy_at(n) !== 16'sd0) begin errors++; $display("FAIL ramp_gy[%0d] got=%0d exp=0", n, gy_at(n)); end
`ifdef GRADIENT_MAG_EN
      checks++; if (Gmag[n*16 +: 16] !== 16'(-exp_gx)) begin errors++; $display("FAIL ramp_mag[%0d] got=%0d exp=%0d", n, Gmag[n*16 +: 16], -exp_gx); end
`endif
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_drain got=%b exp=0", out_valid); end
    $display("test_ramp ksel=%0d exp_gx=%0d done", ksel, exp_gx);
  endtask

  task automatic test_step();
    int exp_col [4] = '{0, 1020, 1020, 0};
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        window[(r*6+c)*8 +: 8] = (c < 3) ? 8'd255 : 8'd0;
    kernel_sel = 1'b0; win_valid = 1'b1; out_ready = 1'b1;
    step();
    win_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL step_valid got=%b exp=1", out_valid); end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        checks++; if (gx_at(i*4+j) !== 16'(exp_col[j])) begin errors++; $display("FAIL step_gx(%0d,%0d) got=%0d exp=%0d", i, j, gx_at(i*4+j), exp_col[j]); end
        checks++; if (gy_at(i*4+j) !== 16'sd0) begin errors++; $display("FAIL step_gy(%0d,%0d) got=%0d exp=0", i, j, gy_at(i*4+j)); end
`ifdef GRADIENT_MAG_EN
        checks++; if (Gmag[(i*4+j)*16 +: 16] !== 16'(exp_col[j])) begin errors++; $display("FAIL step_mag(%0d,%0d) got=%0d exp=%0d", i, j, Gmag[(i*4+j)*16 +: 16], exp_col[j]); end
`endif
      end
    end
    step();
    $display("test_step done");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; kernel_sel = 1'b0;
    for (int t = 0; t < 9; t++) begin
      if (t < 8) begin
        checks++; if (win_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready t=%0d got=%b exp=1", t, win_ready); end
        set_ramp(t + 1); win_valid = 1'b1;
      end else begin
        win_valid = 1'b0;
      end
      step();
      if (t == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_first got=%b exp=0", out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid t=%0d got=%b exp=1", t, out_valid); end
        checks++; if (gx_at(0) !== 16'(-8*t)) begin errors++; $display("FAIL b2b_gx0 t=%0d got=%0d exp=%0d", t, gx_at(0), -8*t); end
        checks++; if (gx_at(15) !== 16'(-8*t)) begin errors++; $display("FAIL b2b_gx15 t=%0d got=%0d exp=%0d", t, gx_at(15), -8*t); end
      end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; kernel_sel = 1'b0;
    set_ramp(1); win_valid = 1'b1;
    checks++; if (win_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got=%b exp=1", win_ready); end
    step();
    set_ramp(2);
    checks++; if (win_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%b exp=1", win_ready); end
    step();
    set_ramp(3);
    for (int k = 0; k < 3; k++) begin
      checks++; if (win_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready k=%0d got=%b exp=0", k, win_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid k=%0d got=%b exp=1", k, out_valid); end
      checks++; if (gx_at(5) !== -16'sd8) begin errors++; $display("FAIL bp_stall_gx k=%0d got=%0d exp=-8", k, gx_at(5)); end
      step();
    end
    win_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (win_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", win_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got=%b exp=1", out_valid); end
    checks++; if (gx_at(5) !== -16'sd16) begin errors++; $display("FAIL bp_second_gx got=%0d exp=-16", gx_at(5)); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; kernel_sel = 1'b0;
    set_ramp(5); win_valid = 1'b1;
    step();
    set_ramp(6);
    step();
    win_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
    checks++; if (Gx !== '0) begin errors++; $display("FAIL mid_async_gx got=%h exp=0", Gx); end
    checks++; if (Gy !== '0) begin errors++; $display("FAIL mid_async_gy got=%h exp=0", Gy); end
    checks++; if (win_ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready got=%b exp=1", win_ready); end
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale k=%0d got=%b exp=0", k, out_valid); end
    end
    $display("test_reset_midflight done");
  endtask

  task automatic test_small_window();
    window3 = '0;
    for (int c = 0; c < 3; c++) window3[c*10 +: 10] = 10'd1023;
    kernel_sel3 = 1'b0; out_ready3 = 1'b1; win_valid3 = 1'b1;
    step();
    win_valid3 = 1'b0;
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL small_latency got=%b exp=0", out_valid3); end
    step();
    checks++; if (out_valid3 !== 1'b1) begin errors++; $display("FAIL small_valid got=%b exp=1", out_valid3); end
    checks++; if (Gy3 !== 13'sd4092) begin errors++; $display("FAIL small_gy got=%0d exp=4092", $signed(Gy3)); end
    checks++; if (Gx3 !== 13'sd0) begin errors++; $display("FAIL small_gx got=%0d exp=0", $signed(Gx3)); end
`ifdef GRADIENT_MAG_EN
    checks++; if (Gmag3 !== 13'd4092) begin errors++; $display("FAIL small_mag got=%0d exp=4092", Gmag3); end
`endif
    step();
    $display("test_small_window done");
  endtask

  initial begin
    test_reset();
    test_ramp(1'b0, -80);
    test_ramp(1'b1, -60);
    test_step();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_small_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gradient_pipe.md
Name: gradient_pipe

Overview:
- Parametrised successor to the fixed 6x6 gradient stage in the corner-detection datapath.
- Takes a WIN x WIN pixel window and produces signed horizontal and vertical 3x3 gradients (Gx, Gy) at every valid interior position, giving (WIN-2)^2 results per axis.
- Feeds the structure-tensor stage downstream.
- Adds a valid/ready handshake with backpressure, a 2-stage pipeline and a runtime Sobel/Prewitt kernel select.

Parameters:
- PIX_W, 8: unsigned pixel width.
- WIN, 6: window side in pixels; must be >= 3; OUT_N = WIN-2 gradient positions per side.
- OUT_W, 16: signed two's-complement gradient width; must be >= PIX_W+3 (elaboration-time check, fatal if violated).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- win_valid  in  1  window present on window.
- win_ready  out  1  block accepts window this cycle.
- window  in  PIX_W*WIN*WIN  pixel [r][c] at bits (r*WIN+c)*PIX_W +: PIX_W.
- kernel_sel  in  1  0 = Sobel (centre weight 2), 1 = Prewitt (centre weight 1); sampled with window.
- out_valid  out  1  Gx/Gy hold a result.
- out_ready  in  1  downstream accepts result.
- Gx  out  OUT_W*OUT_N*OUT_N  element (i,j) at bits (i*OUT_N+j)*OUT_W +: OUT_W, signed.
- Gy  out  OUT_W*OUT_N*OUT_N  same packing, signed.

Behaviour:
- Kernel weight k = 2 (Sobel) or 1 (Prewitt). For position (i,j), with p[r][c] = window[i+r][j+c]:
  - Gx = p[0][0]-p[0][2] + k*(p[1][0]-p[1][2]) + p[2][0]-p[2][2]
  - Gy = p[0][0]-p[2][0] + k*(p[0][1]-p[2][1]) + p[0][2]-p[2][2]
- Arithmetic: pixels zero-extended to PIX_W+1 signed before subtracting. All sums are exact. Results are sign-extended to OUT_W, with no wrap.
- Stage 1 (s1), on accept: registers per-row horizontal differences dh[r][c] = w[r][c]-w[r][c+2] and per-column vertical differences dv[r][c] = w[r][c]-w[r+2][c], each PIX_W+1 bits signed. Also registers kernel_sel and sets s1_valid.
- Stage 2 (s2): registers the weighted 3-term sums into the Gx/Gy output registers and sets out_valid.
- Latency: a window accepted at edge N appears with out_valid=1 after edge N+2.
- Advance enable: en = !out_valid || out_ready.
  - win_ready = en, combinational; it does not depend on win_valid.
  - Transfer in occurs when win_valid && win_ready.
- On en=1:
  - s1_valid <= win_valid.
  - out_valid <= s1_valid.
  - Data registers load only when their stage's incoming valid is 1; otherwise they hold their previous value.
- On en=0: all stage registers and valids hold. Gx/Gy are stable while out_valid && !out_ready.
- Throughput: 1 window/cycle when out_ready is held at 1. Bubbles propagate; there is no internal collapsing of bubbles.
- Simultaneous events:
  - out_valid=1, out_ready=1, win_valid=1 in the same cycle: output consumed, pipeline shifts and new window accepted, all at one edge.
  - kernel_sel changes while a window is in flight: no effect on in-flight results.
- Reset, asserted at any time including mid-transfer:
  - Immediately clears s1_valid, out_valid, Gx, Gy, all stage data and kernel registers to 0.
  - win_ready reads 1 during reset.
  - In-flight windows are discarded; the first result after deassertion comes only from a window accepted after deassertion.
- X-safety: window content is ignored when win_valid=0.

Optional Feature:
- Macro: GRADIENT_MAG_EN.
- Defined:
  - Adds output port Gmag (OUT_W*OUT_N*OUT_N, unsigned, same packing).
  - Gmag(i,j) = |Gx(i,j)| + |Gy(i,j)|, computed in stage 2.
  - Same latency, valid, hold and reset rules as Gx/Gy.
  - Width is ample because OUT_W >= PIX_W+3.
- Undefined: no Gmag port and no magnitude logic; all other behaviour is identical.

Test Plan:
- Ramp window w[r][c]=10*c, WIN=6, kernel_sel=0, out_ready=1 -> 2 cycles later all 16 Gx=-80, all Gy=0; with kernel_sel=1 -> Gx=-60.
- Step window: columns 0..2 = 255, columns 3..5 = 0, Sobel. Expect Gx(i,0)=0, Gx(i,1)=+1020, Gx(i,2)=+1020, Gx(i,3)=0, Gy=0. Gmag(i,1)=1020 when GRADIENT_MAG_EN is defined.
- Back-to-back stream of 8 windows with out_ready=1 -> 8 consecutive out_valid cycles in order, win_ready never drops.
- Hold out_ready=0 with 3 windows offered -> 2 accepted, then win_ready=0. Gx/Gy stay stable. Releasing out_ready drains both results in order with no loss or duplication.
- Assert reset while s1_valid=1 and out_valid=1 -> outputs and valids read 0 immediately (asynchronously). After release, no stale result emerges.
- Parameters PIX_W=10, WIN=3, OUT_W=13, vertical step (top row 1023, rows 1-2 = 0), Sobel -> single Gy=+4092, Gx=0.
